// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, word type and arbiter state encoding.
package cpu_types_pkg;

    localparam int WORD_WIDTH = 32;

    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the data master, the instruction requesters, the arbiter and the RAM.
interface ram_port_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
);

    // data master side
    logic                        dREN;
    logic                        dWEN;
    logic [WORD_W-1:0]           daddr;
    logic [WORD_W-1:0]           dstore;
    logic                        dwait;
    logic [WORD_W-1:0]           dload;

    // instruction fetch side
    logic [CPUS-1:0]             iREN;
    logic [CPUS-1:0][WORD_W-1:0] iaddr;
    logic [CPUS-1:0]             iwait;
    logic [CPUS-1:0][WORD_W-1:0] iload;

    // RAM side
    logic                        ramREN;
    logic                        ramWEN;
    logic [WORD_W-1:0]           ramaddr;
    logic [WORD_W-1:0]           ramstore;
    logic [WORD_W-1:0]           ramload;
    ramstate_t                   ramstate;
    logic                        ram_err;

    // The arbiter itself.
    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    // Everything around the arbiter: requesters and the RAM.
    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo CPUS.
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic [CPUS-1:0]                 req,
    input  logic [idx_width(CPUS)-1:0]      ptr,
    output logic                            valid,
    output logic [idx_width(CPUS)-1:0]      idx
);

    localparam int IDX_W = idx_width(CPUS);

    logic [IDX_W-1:0] slot;

    // Scan from the farthest slot back to ptr so the nearest requester wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        slot  = '0;
        for (int off = CPUS - 1; off >= 0; off--) begin
            slot = IDX_W'((int'(ptr) + off) % CPUS);
            if (req[slot]) begin
                valid = 1'b1;
                idx   = slot;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single RAM port shared by one data master and CPUS instruction fetchers.
// Data wins unless instruction fetch has been starved for STARVE_MAX data grants.
module ram_port_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS       = 2,
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic               CLK,
    input logic               nRST,
    ram_port_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(CPUS);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] cur_cpu, cur_cpu_n;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
    logic [STV_W-1:0] starve_cnt, starve_cnt_n;
    logic             ram_err_q, ram_err_n;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             data_req;
    logic             starve_sat;

    rr_pick #(.CPUS(CPUS)) u_rr_pick (
        .req   (bus.iREN),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign data_req    = bus.dREN | bus.dWEN;
    assign starve_sat  = (starve_cnt == STV_W'(STARVE_MAX));
    assign bus.ram_err = ram_err_q;

    // State and bookkeeping registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!nRST) begin
            state      <= IDLE;
            cur_cpu    <= '0;
            rr_ptr     <= '0;
            starve_cnt <= '0;
            ram_err_q  <= 1'b0;
        end else begin
            state      <= state_n;
            cur_cpu    <= cur_cpu_n;
            rr_ptr     <= rr_ptr_n;
            starve_cnt <= starve_cnt_n;
            ram_err_q  <= ram_err_n;
        end
    end

    // Grant selection and RAM/requester steering; enables follow the live request lines.
    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_n      = state;
        cur_cpu_n    = cur_cpu;
        rr_ptr_n     = rr_ptr;
        starve_cnt_n = starve_cnt;
        ram_err_n    = ram_err_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.dwait    = 1'b1;
        bus.dload    = '0;
        bus.iwait    = '1;
        bus.iload    = '0;

        unique case (state)
            IDLE: begin
                if (pick_valid && starve_sat) begin
                    state_n   = IGRANT;
                    cur_cpu_n = pick_idx;
                end else if (data_req) begin
                    state_n = DGRANT;
                end else if (pick_valid) begin
                    state_n   = IGRANT;
                    cur_cpu_n = pick_idx;
                end
            end

            DGRANT: begin
                if (!data_req) begin
                    state_n = IDLE;
                end else begin
                    bus.ramaddr = bus.daddr;
                    if (bus.dWEN) begin
                        bus.ramWEN   = 1'b1;
                        bus.ramstore = bus.dstore;
                    end else begin
                        bus.ramREN = 1'b1;
                        bus.dload  = bus.ramload;
                    end
                    if (bus.ramstate == ACCESS) begin
                        bus.dwait = 1'b0;
                        state_n   = IDLE;
                        if (|bus.iREN)
                            starve_cnt_n = starve_sat ? starve_cnt : starve_cnt + STV_W'(1);
                        else
                            starve_cnt_n = '0;
                    end else if (bus.ramstate == ERROR) begin
                        state_n   = IDLE;
                        ram_err_n = 1'b1;
                    end
                end
            end

            IGRANT: begin
                if (!bus.iREN[cur_cpu]) begin
                    state_n = IDLE;
                end else begin
                    bus.ramREN         = 1'b1;
                    bus.ramaddr        = bus.iaddr[cur_cpu];
                    bus.iload[cur_cpu] = bus.ramload;
                    if (bus.ramstate == ACCESS) begin
                        bus.iwait[cur_cpu] = 1'b0;
                        state_n            = IDLE;
                        rr_ptr_n           = (int'(cur_cpu) == CPUS - 1) ? '0 : cur_cpu + IDX_W'(1);
                        starve_cnt_n       = '0;
                    end else if (bus.ramstate == ERROR) begin
                        state_n   = IDLE;
                        ram_err_n = 1'b1;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized scoreboard run against a
// transaction-level arbitration model and a RAM model with random latency.
module tb_ram_port_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS       = 2;
    localparam int WORD_W     = 32;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    ram_port_arbiter_if #(.CPUS(CPUS), .WORD_W(WORD_W)) bus ();

    ram_port_arbiter #(.CPUS(CPUS), .WORD_W(WORD_W), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- RAM model ----------------
    logic [31:0] mem [256];
    int          lat_mode    = 0;   // <0: random 0..3 busy cycles
    int          err_req     = 0;
    int          err_done    = 0;
    int          busy_left   = 0;

    assign bus.ramload = mem[bus.ramaddr[7:0]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        bus.ramstate = FREE;
        forever begin
            @(posedge CLK);
            #2;
            if (!(bus.ramREN || bus.ramWEN)) begin
                bus.ramstate = FREE;
                busy_left    = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end else if (busy_left > 0) begin
                bus.ramstate = BUSY;
                busy_left--;
            end else if (err_done < err_req) begin
                bus.ramstate = ERROR;
                err_done++;
            end else begin
                bus.ramstate = ACCESS;
                if (bus.ramWEN) mem[bus.ramaddr[7:0]] = bus.ramstore;
            end
        end
    end

    // ---------------- scoreboard + arbitration model ----------------
    logic [31:0] ref_mem [256];
    exp_t        dq  [$];
    exp_t        iq0 [$];
    exp_t        iq1 [$];
    bit          mon_en = 1'b0;

    initial begin
        int          m_starve, m_rr, cur_win, win;
        bit          prev_en, prev_done, prev_pd, en, done_now;
        logic [1:0]  prev_pi;
        logic [31:0] exp_addr;
        exp_t        e;
        m_starve = 0; m_rr = 0; cur_win = -1;
        prev_en = 0; prev_done = 0; prev_pd = 0; prev_pi = '0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                m_starve = 0; m_rr = 0; cur_win = -1;
                prev_en = 0; prev_done = 0; prev_pd = 0; prev_pi = '0;
                continue;
            end
            en       = bus.ramREN | bus.ramWEN;
            done_now = !bus.dwait || (bus.iwait != 2'b11);
            if (mon_en) begin
                if (done_now)
                    check("one_wait_low", 32'($countones(~bus.iwait)) + (bus.dwait ? 32'd0 : 32'd1), 32'd1);
                if (prev_done)
                    check("idle_gap", 32'(en), 32'd0);
                if (en && !prev_en) begin
                    // Winner from the requests seen during the IDLE cycle.
                    win = -1;
                    for (int k = CPUS - 1; k >= 0; k--)
                        if (prev_pi[(m_rr + k) % CPUS]) win = ((m_rr + k) % CPUS) + 1;
                    if (!((prev_pi != 0) && (m_starve == STARVE_MAX)) && prev_pd) win = 0;
                    cur_win  = win;
                    exp_addr = (win == 0) ? bus.daddr : (win > 0) ? bus.iaddr[win - 1] : 32'hFFFF_FFFF;
                    check("grant_addr", bus.ramaddr, exp_addr);
                end
                if (!bus.dwait) begin
                    check("owner_data", 32'(cur_win), 32'd0);
                    if (dq.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL dq_underflow: got data completion, expected none");
                    end else begin
                        e = dq.pop_front();
                        check("d_addr", bus.ramaddr, e.addr);
                        if (e.wr) begin
                            check("d_wen", {bus.ramWEN, bus.ramREN}, 2'b10);
                            check("d_store", bus.ramstore, e.data);
                        end else begin
                            check("d_ren", {bus.ramWEN, bus.ramREN}, 2'b01);
                            check("d_load", bus.dload, e.data);
                        end
                    end
                    if (bus.iREN != 0) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
                    else m_starve = 0;
                end
                for (int k = 0; k < CPUS; k++) begin
                    if (!bus.iwait[k]) begin
                        check("owner_cpu", 32'(cur_win), 32'(k + 1));
                        if ((k == 0 ? iq0.size() : iq1.size()) == 0) begin
                            n_vec++; n_fail++;
                            $display("FAIL iq_underflow: got cpu%0d completion, expected none", k);
                        end else begin
                            e = (k == 0) ? iq0.pop_front() : iq1.pop_front();
                            check("i_addr", bus.ramaddr, e.addr);
                            check("i_load", bus.iload[k], e.data);
                        end
                        m_rr     = (k + 1) % CPUS;
                        m_starve = 0;
                    end
                end
            end
            prev_en   = en;
            prev_done = done_now;
            prev_pd   = bus.dREN | bus.dWEN;
            prev_pi   = bus.iREN;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // who: 0 data, 1 cpu0, 2 cpu1, -1 timeout
    task automatic wait_done(output int who, input int budget);
        who = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge CLK);
            if (!bus.dwait) begin who = 0; return; end
            for (int k = 0; k < CPUS; k++)
                if (!bus.iwait[k]) begin who = k + 1; return; end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int who;
        int d_left, d_active, d_done;
        int c_left [CPUS];
        int c_active [CPUS];
        int c_done [CPUS];
        logic [31:0] a, v;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = 32'h88; bus.dstore = '0;
        bus.iREN = '0;   bus.iaddr = '0;
        nRST = 1'b0;

        // Reset held with a pending data read.
        repeat (2) @(negedge CLK);
        check("rst_ramREN", 32'(bus.ramREN), 32'd0);
        check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        check("rst_dwait", 32'(bus.dwait), 32'd1);
        check("rst_iwait", 32'(bus.iwait), 32'd3);
        check("rst_ramaddr", bus.ramaddr, 32'd0);
        check("rst_dload", bus.dload, 32'd0);
        check("rst_ram_err", 32'(bus.ram_err), 32'd0);
        @(posedge CLK); #1; nRST = 1'b1;
        @(negedge CLK);
        check("post_rst_idle", 32'(bus.ramREN), 32'd0);
        @(negedge CLK);
        check("post_rst_grant", 32'(bus.ramREN), 32'd1);
        check("post_rst_dwait", 32'(bus.dwait), 32'd0);
        check("post_rst_dload", bus.dload, ref_mem[8'h88]);

        // Write with two BUSY cycles before ACCESS; dREN also high to exercise write priority.
        @(posedge CLK); #1;
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
        ref_mem[0] = 32'hDEAD_BEEF; lat_mode = 2;
        @(negedge CLK);
        check("wr_idle", 32'(bus.ramWEN), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("wr_wen", {bus.ramWEN, bus.ramREN}, 2'b10);
            check("wr_addr", bus.ramaddr, 32'h100);
            check("wr_store", bus.ramstore, 32'hDEAD_BEEF);
            check("wr_dwait", 32'(bus.dwait), (i == 2) ? 32'd0 : 32'd1);
        end
        @(posedge CLK); #1;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; lat_mode = 0;
        @(negedge CLK);
        check("wr_release", 32'(bus.ramWEN), 32'd0);

        // Both instruction requesters held: grants rotate 0,1,0.
        @(posedge CLK); #1;
        bus.iREN = 2'b11; bus.iaddr[0] = 32'h10; bus.iaddr[1] = 32'h21;
        for (int g = 0; g < 3; g++) begin
            wait_done(who, 8);
            check("rr_who", 32'(who), (g == 1) ? 32'd2 : 32'd1);
            check("rr_iwait", 32'(bus.iwait), (g == 1) ? 32'd1 : 32'd2);
            check("rr_addr", bus.ramaddr, (g == 1) ? 32'h21 : 32'h10);
            check("rr_iload", bus.iload[(g == 1) ? 1 : 0], ref_mem[(g == 1) ? 8'h21 : 8'h10]);
        end
        @(posedge CLK); #1;
        bus.iREN = '0;

        // Starvation guard: data and cpu0 both held.
        @(posedge CLK); #1;
        bus.dREN = 1'b1; bus.daddr = 32'h90; bus.iREN = 2'b01; bus.iaddr[0] = 32'h12;
        for (int g = 0; g < 10; g++) begin
            wait_done(who, 8);
            check("starve_seq", 32'(who), ((g % 5) == 4) ? 32'd1 : 32'd0);
        end
        @(posedge CLK); #1;
        bus.dREN = 1'b0; bus.iREN = '0;

        // Instruction request dropped mid-grant; rr pointer must stay at cpu1.
        @(posedge CLK); #1;
        lat_mode = 3; bus.iREN = 2'b10; bus.iaddr[1] = 32'h23;
        @(negedge CLK);
        check("drop_idle0", 32'(bus.ramREN), 32'd0);
        @(negedge CLK);
        check("drop_grant", 32'(bus.ramREN), 32'd1);
        check("drop_addr", bus.ramaddr, 32'h23);
        check("drop_iwait", 32'(bus.iwait), 32'd3);
        @(posedge CLK); #1;
        bus.iREN = 2'b00; lat_mode = 0;
        @(negedge CLK);
        check("drop_en_fall", 32'(bus.ramREN), 32'd0);
        @(posedge CLK); #1;
        bus.iREN = 2'b11; bus.iaddr[0] = 32'h14;
        @(negedge CLK);
        check("drop_back_idle", 32'(bus.ramREN), 32'd0);
        @(negedge CLK);
        check("drop_rr_kept", 32'(bus.iwait), 32'd1);
        check("drop_rr_addr", bus.ramaddr, 32'h23);
        @(posedge CLK); #1;
        bus.iREN = '0;

        // ERROR during a data grant: sticky flag, retry after one IDLE cycle.
        @(posedge CLK); #1;
        err_req++; bus.dREN = 1'b1; bus.daddr = 32'h84;
        @(negedge CLK);
        check("err_pre_flag", 32'(bus.ram_err), 32'd0);
        @(negedge CLK);
        check("err_ren", 32'(bus.ramREN), 32'd1);
        check("err_dwait", 32'(bus.dwait), 32'd1);
        @(negedge CLK);
        check("err_flag", 32'(bus.ram_err), 32'd1);
        check("err_idle", 32'(bus.ramREN), 32'd0);
        @(negedge CLK);
        check("err_retry_dwait", 32'(bus.dwait), 32'd0);
        check("err_retry_dload", bus.dload, ref_mem[8'h84]);
        check("err_sticky", 32'(bus.ram_err), 32'd1);
        @(posedge CLK); #1;
        bus.dREN = 1'b0;

        // Randomized phase from a fresh reset.
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        check("rand_rst_err", 32'(bus.ram_err), 32'd0);
        lat_mode = -1;
        mon_en   = 1'b1;
        d_left = 40; d_active = 0; d_done = 0;
        for (int k = 0; k < CPUS; k++) begin c_left[k] = 25; c_active[k] = 0; c_done[k] = 0; end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (d_left == 0 && !d_active && c_left[0] == 0 && !c_active[0] &&
                c_left[1] == 0 && !c_active[1]) break;
            @(posedge CLK); #1;
            if (d_active && d_done) begin
                d_active = 0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
            end
            if (!d_active && d_left > 0 && $urandom_range(0, 1) == 0) begin
                a = 32'h80 + 32'($urandom_range(0, 127));
                if ($urandom_range(0, 1) == 1) begin
                    v = $urandom;
                    ref_mem[a[7:0]] = v;
                    bus.dWEN = 1'b1; bus.dREN = 1'($urandom_range(0, 1));
                    bus.daddr = a; bus.dstore = v;
                    dq.push_back('{wr: 1'b1, addr: a, data: v});
                end else begin
                    bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = a;
                    dq.push_back('{wr: 1'b0, addr: a, data: ref_mem[a[7:0]]});
                end
                d_active = 1; d_left--;
            end
            for (int k = 0; k < CPUS; k++) begin
                if (c_active[k] && c_done[k]) begin
                    c_active[k] = 0; bus.iREN[k] = 1'b0;
                end
                if (!c_active[k] && c_left[k] > 0 && $urandom_range(0, 2) == 0) begin
                    a = (32'($urandom_range(0, 63)) << 1) | 32'(k);
                    bus.iREN[k] = 1'b1; bus.iaddr[k] = a;
                    if (k == 0) iq0.push_back('{wr: 1'b0, addr: a, data: ref_mem[a[7:0]]});
                    else        iq1.push_back('{wr: 1'b0, addr: a, data: ref_mem[a[7:0]]});
                    c_active[k] = 1; c_left[k]--;
                end
            end
            @(negedge CLK);
            d_done = !bus.dwait;
            for (int k = 0; k < CPUS; k++) c_done[k] = !bus.iwait[k];
        end
        check("rand_all_issued", 32'(d_left + c_left[0] + c_left[1]), 32'd0);
        @(posedge CLK); #1;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.iREN = '0;
        repeat (3) @(negedge CLK);
        mon_en = 1'b0;
        check("dq_drained", 32'(dq.size()), 32'd0);
        check("iq0_drained", 32'(iq0.size()), 32'd0);
        check("iq1_drained", 32'(iq1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
